// File: rtl/nn_pkg.sv
// Shared sizes and FSM encoding for the tiny NN parameter loader.
package nn_pkg;

    localparam int unsigned NUM_W     = 11;
    localparam int unsigned NUM_B     = 6;
    localparam int unsigned W_BITS    = 2;
    localparam int unsigned B_BITS    = 4;
    localparam int unsigned CFG_WORDS = NUM_W + NUM_B;
    localparam int unsigned IDX_BITS  = $clog2(CFG_WORDS);
    localparam int unsigned WEIGHTS_W = NUM_W * W_BITS;
    localparam int unsigned BIASES_W  = NUM_B * B_BITS;
    localparam int unsigned X_BITS    = 2;
    localparam int unsigned Y_BITS    = 2;

    typedef enum logic [1:0] {
        StLoad,
        StArmed,
        StEval,
        StResult
    } nn_state_e;

    function automatic logic is_last_word(logic [IDX_BITS-1:0] idx);
        return idx == IDX_BITS'(CFG_WORDS - 1);
    endfunction

endpackage

// File: rtl/nn_param_loader_if.sv
// Config, sample, network and result signals of the parameter loader.
interface nn_param_loader_if;
    import nn_pkg::*;

    logic                   cfg_start;
    logic                   cfg_valid;
    logic [B_BITS-1:0]      cfg_data;
    logic                   cfg_ready;
    logic                   params_loaded;
    logic                   sample_valid;
    logic [2*X_BITS-1:0]    x_in;
    logic                   sample_ready;
    logic [X_BITS-1:0]      x1_o;
    logic [X_BITS-1:0]      x2_o;
    logic [WEIGHTS_W-1:0]   weights_o;
    logic [BIASES_W-1:0]    biases_o;
    logic [Y_BITS-1:0]      y_in;
    logic [Y_BITS-1:0]      y_out;
    logic                   y_valid;
    logic                   y_ready;

    modport master (
        output cfg_start, cfg_valid, cfg_data, sample_valid, x_in, y_in, y_ready,
        input  cfg_ready, params_loaded, sample_ready, x1_o, x2_o, weights_o, biases_o,
               y_out, y_valid
    );

    modport slave (
        input  cfg_start, cfg_valid, cfg_data, sample_valid, x_in, y_in, y_ready,
        output cfg_ready, params_loaded, sample_ready, x1_o, x2_o, weights_o, biases_o,
               y_out, y_valid
    );

endinterface

// File: rtl/nn_param_regfile.sv
// Indexed weight/bias storage; words 0..NUM_W-1 are weights, the rest biases.
module nn_param_regfile
    import nn_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en_i,
    input  logic [IDX_BITS-1:0]  wr_idx_i,
    input  logic [B_BITS-1:0]    wr_data_i,
    output logic [WEIGHTS_W-1:0] weights_o,
    output logic [BIASES_W-1:0]  biases_o
);

    logic [WEIGHTS_W-1:0] weights_d, weights_q;
    logic [BIASES_W-1:0]  biases_d, biases_q;

    always_comb begin
        weights_d = weights_q;
        biases_d  = biases_q;
        if (wr_en_i) begin
            for (int i = 0; i < NUM_W; i++) begin
                if (wr_idx_i == IDX_BITS'(i)) begin
                    weights_d[i*W_BITS +: W_BITS] = wr_data_i[W_BITS-1:0];
                end
            end
            for (int i = 0; i < NUM_B; i++) begin
                if (wr_idx_i == IDX_BITS'(NUM_W + i)) begin
                    biases_d[i*B_BITS +: B_BITS] = wr_data_i;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            weights_q <= '0;
            biases_q  <= '0;
        end else begin
            weights_q <= weights_d;
            biases_q  <= biases_d;
        end
    end

    assign weights_o = weights_q;
    assign biases_o  = biases_q;

endmodule

// File: rtl/nn_param_loader.sv
// Loads the network parameter set, then sequences sample -> evaluate -> result handshakes.
module nn_param_loader
    import nn_pkg::*;
(
    input logic              clk,
    input logic              rst_n,
    nn_param_loader_if.slave bus
);

    nn_state_e             state_d, state_q;
    logic [IDX_BITS-1:0]   idx_d, idx_q;
    logic                  loaded_d, loaded_q;
    logic [X_BITS-1:0]     x1_d, x1_q, x2_d, x2_q;
    logic [Y_BITS-1:0]     y_d, y_q;
    logic                  y_valid_d, y_valid_q;
    logic                  wr_en;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        loaded_d  = loaded_q;
        x1_d      = x1_q;
        x2_d      = x2_q;
        y_d       = y_q;
        y_valid_d = y_valid_q;
        wr_en     = 1'b0;
        case (state_q)
            StLoad: begin
                if (bus.cfg_valid) begin
                    wr_en = 1'b1;
                    if (is_last_word(idx_q)) begin
                        idx_d    = '0;
                        loaded_d = 1'b1;
                        state_d  = StArmed;
                    end else begin
                        idx_d = idx_q + IDX_BITS'(1);
                    end
                end
            end
            StArmed: begin
                // Reload wins over a simultaneous sample; old parameters stay until overwritten.
                if (bus.cfg_start) begin
                    loaded_d = 1'b0;
                    idx_d    = '0;
                    state_d  = StLoad;
                end else if (bus.sample_valid) begin
                    x1_d    = bus.x_in[X_BITS-1:0];
                    x2_d    = bus.x_in[2*X_BITS-1:X_BITS];
                    state_d = StEval;
                end
            end
            StEval: begin
                y_d       = bus.y_in;
                y_valid_d = 1'b1;
                state_d   = StResult;
            end
            StResult: begin
                if (bus.y_ready) begin
                    y_valid_d = 1'b0;
                    state_d   = StArmed;
                end
            end
            default: state_d = StLoad;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StLoad;
            idx_q     <= '0;
            loaded_q  <= 1'b0;
            x1_q      <= '0;
            x2_q      <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            loaded_q  <= loaded_d;
            x1_q      <= x1_d;
            x2_q      <= x2_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
        end
    end

    nn_param_regfile u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (wr_en),
        .wr_idx_i  (idx_q),
        .wr_data_i (bus.cfg_data),
        .weights_o (bus.weights_o),
        .biases_o  (bus.biases_o)
    );

    assign bus.cfg_ready     = (state_q == StLoad);
    assign bus.sample_ready  = (state_q == StArmed);
    assign bus.params_loaded = loaded_q;
    assign bus.x1_o          = x1_q;
    assign bus.x2_o          = x2_q;
    assign bus.y_out         = y_q;
    assign bus.y_valid       = y_valid_q;

endmodule

// File: doc/nn_param_loader.md
NN_PARAM_LOADER -- requirements
Module: nn_param_loader

Interface
REQ-001 Parameters: none; all sizes are fixed constants from nn_pkg.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 cfg_start  input  1  one-cycle request to reload all parameters.
REQ-005 cfg_valid  input  1  cfg_data holds a valid parameter word.
REQ-006 cfg_data  input  4  parameter word; weights use [1:0], biases use [3:0].
REQ-007 cfg_ready  output  1  block accepts a cfg word this cycle.
REQ-008 params_loaded  output  1  full parameter set held.
REQ-009 sample_valid  input  1  x_in holds a valid sample.
REQ-010 x_in  input  4  sample: x1=[1:0], x2=[3:2].
REQ-011 sample_ready  output  1  block accepts a sample this cycle.
REQ-012 x1_o, x2_o  output  2 each  registered inputs to the combinational network.
REQ-013 weights_o  output  22  packed weights, 2 bits each, LSB first: w1,w2,w11,w12,w13,w21,w22,w23,w01,w02,w03.
REQ-014 biases_o  output  24  packed biases, 4 bits each, LSB first: b1..b6.
REQ-015 y_in  input  2  network output y.
REQ-016 y_out  output  2  captured network result.
REQ-017 y_valid / y_ready  output / input  1 each  result handshake.

Function
REQ-018 FSM states SHALL be LOAD, ARMED, EVAL and RESULT.
REQ-019 LOAD: cfg_ready=1; each cycle with cfg_valid high writes word idx (0..16) and increments idx.
REQ-020 Words 0..10 SHALL write weights in REQ-013 order from cfg_data[1:0], ignoring [3:2]; words 11..16 SHALL write b1..b6.
REQ-021 On accepting word 16: idx->0, params_loaded->1 on the next edge, state->ARMED.
REQ-022 ARMED: sample_ready=1; sample_valid high latches x1_o/x2_o and moves to EVAL.
REQ-023 EVAL lasts exactly one cycle; at its closing edge y_out<=y_in, y_valid->1, state->RESULT.
REQ-024 RESULT: y_valid and y_out hold until y_ready is high; y_valid then clears, state->ARMED.
REQ-025 cfg_start in ARMED: params_loaded->0, idx->0, state->LOAD; existing parameters persist until overwritten.
REQ-026 cfg_start is ignored in LOAD, EVAL and RESULT, and has priority over sample_valid in ARMED.
REQ-027 cfg_valid outside LOAD and sample_valid outside ARMED SHALL be ignored with no state change.
REQ-028 weights_o, biases_o and x*_o SHALL be stable through EVAL.

Reset
REQ-029 While rst_n is low at a clock edge: state->LOAD, idx->0, and all registered outputs (x1_o, x2_o, weights_o, biases_o, y_out, y_valid, params_loaded) ->0.
REQ-030 After reset: cfg_ready=1 and sample_ready=0; a reset mid-load discards partial words.

Structure
REQ-031 nn_pkg SHALL hold NUM_W=11, NUM_B=6, W_BITS=2, B_BITS=4, CFG_WORDS=17 and the FSM state enum.
REQ-032 Parameter storage SHALL be one sub-module, nn_param_regfile (write index, data, write enable; packed outputs).

Verification
REQ-033 Reset -> cfg_ready=1, sample_ready=0, weights_o=0, biases_o=0, y_valid=0.
REQ-034 Load 01,01,01,00,11,01,00,10,01,11,00,0,1,3,0,7,3 -> weights_o=22'h0D8715, biases_o=24'h370310, params_loaded=1.
REQ-035 Sample x_in=4'b0100 with y_in=2'b10 -> x1_o=00, x2_o=01; y_valid=1 and y_out=10 at second edge after the handshake.
REQ-036 y_ready held low 5 cycles -> y_valid and y_out stable; sample_ready=0 until release.
REQ-037 Reset asserted after word 7 -> all outputs 0; a fresh 17-word load completes correctly.
REQ-038 cfg_start in ARMED, then 17 zero words -> weights_o=0, biases_o=0; cfg_start in RESULT -> ignored.
